// File: rtl/spi_mem_loader_if.sv
// SPI host pins plus parameter-memory write port of the SPI memory loader.
// addr_err exists only when SPI_LOADER_ERR_EN is defined.
interface spi_mem_loader_if #(
    parameter int N      = 8,
    parameter int ADDR_W = 9
);
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic [N-1:0]      mem_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              busy;
    logic              frame_done;
`ifdef SPI_LOADER_ERR_EN
    logic              addr_err;
`endif

    modport slave (
        input  sclk, cs_n, mosi,
`ifdef SPI_LOADER_ERR_EN
        output addr_err,
`endif
        output mem_data, mem_addr, mem_we, busy, frame_done
    );

    modport master (
        output sclk, cs_n, mosi,
`ifdef SPI_LOADER_ERR_EN
        input  addr_err,
`endif
        input  mem_data, mem_addr, mem_we, busy, frame_done
    );
endinterface

// File: rtl/spi_mem_loader.sv
// SPI mode-0 frame receiver: 16-bit start address then N-bit words, each written to parameter memory.
// Optional sticky invalid-address flag addr_err is enabled by defining SPI_LOADER_ERR_EN.
module spi_mem_loader #(
    parameter int M      = 320,
    parameter int N      = 8,
    parameter int ADDR_W = $clog2(M)
) (
    input  logic            clk,
    input  logic            reset,
    spi_mem_loader_if.slave bus
);
    localparam int SW = (N > 8) ? N : 8;
    localparam int CW = $clog2(SW + 1);

    localparam logic [15:0]       M16       = 16'(M);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(M - 1);
    localparam logic [CW-1:0]     BYTE_LAST = CW'(7);
    localparam logic [CW-1:0]     WORD_LAST = CW'(N - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ADDR_HI = 3'd1;
    localparam logic [2:0] ADDR_LO = 3'd2;
    localparam logic [2:0] DATA    = 3'd3;
    localparam logic [2:0] DROP    = 3'd4;

    logic [1:0]        sclk_sync;
    logic [1:0]        cs_sync;
    logic [1:0]        mosi_sync;
    logic              sclk_prev;
    logic [1:0]        sync_fill;

    logic [2:0]        state;
    logic [CW-1:0]     bit_cnt;
    logic [SW-2:0]     shift_reg;
    logic [7:0]        addr_hi;
    logic [ADDR_W-1:0] ptr;
    logic              wrote;
    logic              armed;

    logic [N-1:0]      mem_data_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic              frame_done_q;

    logic              cs_s;
    logic              sclk_rise;
    logic [SW-1:0]     shift_next;
    logic [15:0]       start_addr;
    logic              addr_ok;
    logic              byte_done;
    logic              word_done;

    // cs_n resets to the inactive level so busy reads 0 while reset is held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_prev <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[0], bus.sclk};
            cs_sync   <= {cs_sync[0], bus.cs_n};
            mosi_sync <= {mosi_sync[0], bus.mosi};
            sclk_prev <= sclk_sync[1];
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    assign cs_s       = cs_sync[1];
    assign sclk_rise  = sclk_sync[1] & ~sclk_prev;
    assign shift_next = {shift_reg, mosi_sync[1]};
    assign start_addr = {addr_hi, shift_next[7:0]};
    assign addr_ok    = (start_addr < M16);
    assign byte_done  = sclk_rise && (bit_cnt == BYTE_LAST);
    assign word_done  = sclk_rise && (bit_cnt == WORD_LAST);

    // armed only after a genuine cs_n high is seen, so a frame open across reset is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            addr_hi      <= '0;
            ptr          <= '0;
            wrote        <= 1'b0;
            armed        <= 1'b0;
            mem_data_q   <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            mem_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            if (sync_fill[1] && cs_s) begin
                armed <= 1'b1;
            end
            if (cs_s) begin
                if (state != IDLE) begin
                    state        <= IDLE;
                    frame_done_q <= wrote;
                end
                bit_cnt <= '0;
                wrote   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= armed ? ADDR_HI : DROP;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        wrote     <= 1'b0;
                    end
                    ADDR_HI: begin
                        if (sclk_rise) begin
                            shift_reg <= shift_next[SW-2:0];
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                        if (byte_done) begin
                            addr_hi <= shift_next[7:0];
                            bit_cnt <= '0;
                            state   <= ADDR_LO;
                        end
                    end
                    ADDR_LO: begin
                        if (sclk_rise) begin
                            shift_reg <= shift_next[SW-2:0];
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                        if (byte_done) begin
                            bit_cnt <= '0;
                            if (addr_ok) begin
                                ptr   <= start_addr[ADDR_W-1:0];
                                state <= DATA;
                            end else begin
                                state <= DROP;
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_rise) begin
                            shift_reg <= shift_next[SW-2:0];
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                        if (word_done) begin
                            bit_cnt    <= '0;
                            mem_we_q   <= 1'b1;
                            mem_data_q <= shift_next[N-1:0];
                            mem_addr_q <= ptr;
                            ptr        <= (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
                            wrote      <= 1'b1;
                        end
                    end
                    DROP: begin
                        bit_cnt <= '0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef SPI_LOADER_ERR_EN
    logic addr_err_q;

    // Sticky until a later frame passes the address check
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_err_q <= 1'b0;
        end else if (!cs_s && state == ADDR_LO && byte_done) begin
            addr_err_q <= ~addr_ok;
        end
    end

    assign bus.addr_err = addr_err_q;
`endif

    assign bus.mem_data   = mem_data_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = ~cs_s;
endmodule

// File: tb/tb_spi_mem_loader.sv
// Directed self-checking bench for spi_mem_loader; a negedge monitor logs writes and pulses.
// Builds with or without SPI_LOADER_ERR_EN.
`timescale 1ns/1ps
module tb_spi_mem_loader;
    localparam int M      = 320;
    localparam int N      = 8;
    localparam int ADDR_W = $clog2(M);
    localparam int HALF   = 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    spi_mem_loader_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

    spi_mem_loader #(.M(M), .N(N), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] wr_q[$];
    int          done_cnt = 0;
    int          wide_we  = 0;
    int          overlap  = 0;
    logic        we_prev  = 1'b0;

    // Each entry is {addr in upper 16 bits, data in lower 16 bits}
    always @(negedge clk) begin
        if (bus.mem_we) wr_q.push_back({7'd0, bus.mem_addr, 8'd0, bus.mem_data});
        if (bus.mem_we && we_prev) wide_we++;
        if (bus.mem_we && bus.frame_done) overlap++;
        if (bus.frame_done) done_cnt++;
        we_prev = bus.mem_we;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic send_bits(input logic [15:0] value, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.mosi = value[i];
            #HALF bus.sclk = 1'b1;
            #HALF bus.sclk = 1'b0;
        end
    endtask

    task automatic frame_start();
        bus.cs_n = 1'b0;
        #HALF;
    endtask

    task automatic frame_end(input int idle_ns);
        #HALF;
        bus.cs_n = 1'b1;
        #idle_ns;
    endtask

    int          base;
    int          done_base;
    logic [31:0] exp6 [8];

    initial begin
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        check_output("rst_we",   {31'd0, bus.mem_we}, 32'd0);
        check_output("rst_data", {24'd0, bus.mem_data}, 32'd0);
        check_output("rst_addr", {23'd0, bus.mem_addr}, 32'd0);
        check_output("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_output("rst_done", {31'd0, bus.frame_done}, 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] frame at 0x0000, two bytes");
        base = wr_q.size(); done_base = done_cnt;
        frame_start();
        send_bits(16'h0000, 16);
        send_bits(16'h00A5, 8);
        send_bits(16'h003C, 8);
        frame_end(80);
        check_output("t1_count", wr_q.size() - base, 32'd2);
        check_output("t1_w0", wr_q[base], 32'h0000_00A5);
        check_output("t1_w1", wr_q[base + 1], 32'h0001_003C);
        check_output("t1_done", done_cnt - done_base, 32'd1);

        $display("[TB] frame at 318 wrapping past M-1");
        base = wr_q.size(); done_base = done_cnt;
        frame_start();
        send_bits(16'h013E, 16);
        send_bits(16'h0011, 8);
        send_bits(16'h0022, 8);
        send_bits(16'h0033, 8);
        frame_end(80);
        check_output("t2_count", wr_q.size() - base, 32'd3);
        check_output("t2_w0", wr_q[base], 32'h013E_0011);
        check_output("t2_w1", wr_q[base + 1], 32'h013F_0022);
        check_output("t2_w2", wr_q[base + 2], 32'h0000_0033);
        check_output("t2_done", done_cnt - done_base, 32'd1);

        $display("[TB] out-of-range address 320, then valid frame at 5");
        base = wr_q.size(); done_base = done_cnt;
        frame_start();
        send_bits(16'h0140, 16);
        send_bits(16'h00AA, 8);
        send_bits(16'h0055, 8);
        frame_end(80);
        check_output("t3_bad_count", wr_q.size() - base, 32'd0);
        check_output("t3_bad_done", done_cnt - done_base, 32'd0);
`ifdef SPI_LOADER_ERR_EN
        check_output("t3_err_set", {31'd0, bus.addr_err}, 32'd1);
`endif
        base = wr_q.size(); done_base = done_cnt;
        frame_start();
        send_bits(16'h0005, 16);
        send_bits(16'h005A, 8);
        frame_end(80);
        check_output("t3_ok_count", wr_q.size() - base, 32'd1);
        check_output("t3_ok_w0", wr_q[base], 32'h0005_005A);
        check_output("t3_ok_done", done_cnt - done_base, 32'd1);
`ifdef SPI_LOADER_ERR_EN
        check_output("t3_err_clr", {31'd0, bus.addr_err}, 32'd0);
`endif

        $display("[TB] one byte then a partial byte");
        base = wr_q.size(); done_base = done_cnt;
        frame_start();
        send_bits(16'h0010, 16);
        send_bits(16'h007E, 8);
        send_bits(16'h0015, 5);
        check_output("t4_busy", {31'd0, bus.busy}, 32'd1);
        frame_end(80);
        check_output("t4_count", wr_q.size() - base, 32'd1);
        check_output("t4_w0", wr_q[base], 32'h0010_007E);
        check_output("t4_done", done_cnt - done_base, 32'd1);
        check_output("t4_idle_busy", {31'd0, bus.busy}, 32'd0);

        $display("[TB] reset in the middle of a data byte");
        base = wr_q.size(); done_base = done_cnt;
        frame_start();
        send_bits(16'h0020, 16);
        send_bits(16'h000B, 4);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_output("t5_rst_we",   {31'd0, bus.mem_we}, 32'd0);
        check_output("t5_rst_data", {24'd0, bus.mem_data}, 32'd0);
        check_output("t5_rst_addr", {23'd0, bus.mem_addr}, 32'd0);
        check_output("t5_rst_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        #40;
        send_bits(16'h0000, 16);
        send_bits(16'h0055, 8);
        frame_end(80);
        check_output("t5_drop_count", wr_q.size() - base, 32'd0);
        check_output("t5_drop_done", done_cnt - done_base, 32'd0);
        base = wr_q.size(); done_base = done_cnt;
        frame_start();
        send_bits(16'h0020, 16);
        send_bits(16'h0099, 8);
        frame_end(80);
        check_output("t5_new_count", wr_q.size() - base, 32'd1);
        check_output("t5_new_w0", wr_q[base], 32'h0020_0099);
        check_output("t5_new_done", done_cnt - done_base, 32'd1);

        $display("[TB] back-to-back frames at sclk = clk/4");
        exp6 = '{32'h0100_0001, 32'h0101_0002, 32'h0102_0003, 32'h0103_0004,
                 32'h0050_00F0, 32'h0051_00F1, 32'h0052_00F2, 32'h0053_00F3};
        base = wr_q.size(); done_base = done_cnt;
        frame_start();
        send_bits(16'h0100, 16);
        send_bits(16'h0001, 8);
        send_bits(16'h0002, 8);
        send_bits(16'h0003, 8);
        send_bits(16'h0004, 8);
        frame_end(40);
        frame_start();
        send_bits(16'h0050, 16);
        send_bits(16'h00F0, 8);
        send_bits(16'h00F1, 8);
        send_bits(16'h00F2, 8);
        send_bits(16'h00F3, 8);
        frame_end(80);
        check_output("t6_count", wr_q.size() - base, 32'd8);
        for (int k = 0; k < 8; k++) begin
            check_output($sformatf("t6_w%0d", k), wr_q[base + k], exp6[k]);
        end
        check_output("t6_done", done_cnt - done_base, 32'd2);
        check_output("we_width", wide_we, 32'd0);
        check_output("we_done_overlap", overlap, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
